// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready request/response front end for the banked main-memory array.
// Sequences mem_cs/mem_we/mem_oe, owns the shared data bus only while writing,
// captures synchronous read data and returns it over a valid/ready response channel.
// Optional write read-back verification: define MEM_REQ_CTRL_WR_VERIFY_EN.
module mem_req_ctrl #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
        ,
        VF_ADDR = 3'd5,
        VF_DATA = 3'd6
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
    logic                  wr_err_q, wr_err_d;
`endif

    // Ready is a decode of the state register, forced low while reset is held
    assign req_ready = (state_q == IDLE) && !rst;

    // Next-state, request capture, response capture and control decode for the coming state
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
        wr_err_d    = wr_err_q;
`endif
        cs_d        = 1'b0;
        we_d        = 1'b0;
        oe_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WRITE : RD_ADDR;
                end
            end
            WRITE: begin
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
                state_d = VF_ADDR;
`else
                state_d = IDLE;
`endif
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                // array has registered the word at the previous edge and drives it now
                rsp_rdata_d = mem_data;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
            VF_ADDR: state_d = VF_DATA;
            VF_DATA: begin
                if (mem_data != wdata_q) begin
                    wr_err_d = 1'b1;
                end
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // controls are registered alongside the state they belong to
        case (state_d)
            WRITE: begin
                cs_d = 1'b1;
                we_d = 1'b1;
            end
            RD_ADDR, RD_DATA: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
            end
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
            VF_ADDR, VF_DATA: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
            end
`endif
            default: begin
                cs_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
        end
    end

`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
    // Sticky read-back mismatch flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end
    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;

    // The bus is ours only during the write cycle; otherwise released to the array
    assign mem_data  = we_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: behavioural synchronous memory array on the shared bus,
// a table of directed write/read vectors, multi-cycle reset/backpressure/verify
// sequences, and random traffic checked against a flat reference memory.
// Honours MEM_REQ_CTRL_WR_VERIFY_EN when it is defined for the build.
module tb_mem_req_ctrl;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
    localparam int WR_CYC = 3;
`else
    localparam int WR_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          wr_err;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs, mem_we, mem_oe;

    int checks = 0;
    int errors = 0;

    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .wr_err(wr_err), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    always #5 clk = ~clk;

    // Behavioural array: write on cs&we, one-cycle registered read, drives bus on cs&oe&!we
    logic [DW-1:0] arr [0:(1<<AW)-1];
    logic [DW-1:0] arr_q = '0;
    logic          corrupt = 1'b0;
    initial for (int i = 0; i < (1 << AW); i++) arr[i] = '0;
    always @(posedge clk) begin
        if (mem_cs && mem_we) arr[mem_addr] <= mem_data;
        if (mem_cs && mem_oe && !mem_we) arr_q <= arr[mem_addr];
    end
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? (corrupt ? ~arr_q : arr_q) : {DW{1'bz}};

    // Reference: what each address must hold after the completed writes
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {29'd0, mem_cs, mem_we, mem_oe};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        wait_ready(tag);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " wr_ctl"},  ctl(), 32'b110);
        chk({tag, " wr_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, " wr_bus"},  32'(mem_data), 32'(d));
        chk({tag, " wr_busy"}, 32'(req_ready), 32'd0);
        for (int i = 1; i < WR_CYC; i++) begin
            @(negedge clk);
            chk({tag, " vf_ctl"},  ctl(), 32'b101);
            chk({tag, " vf_busy"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk({tag, " wr_done_rdy"}, 32'(req_ready), 32'd1);
        chk({tag, " wr_done_ctl"}, ctl(), 32'b000);
        chk({tag, " wr_no_rsp"},   32'(rsp_valid), 32'd0);
        ref_mem[int'(a)] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold, input logic [DW-1:0] exp,
                           input string tag);
        wait_ready(tag);
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = DW'($urandom);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " rda_ctl"},  ctl(), 32'b101);
        chk({tag, " rda_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, " rda_busy"}, 32'(req_ready), 32'd0);
        chk({tag, " rda_vld"},  32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " rdd_ctl"}, ctl(), 32'b101);
        chk({tag, " rdd_vld"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " rsp_vld"},  32'(rsp_valid), 32'd1);
        chk({tag, " rsp_data"}, 32'(rsp_rdata), 32'(exp));
        chk({tag, " rsp_ctl"},  ctl(), 32'b000);
        chk({tag, " rsp_busy"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " bp_vld"},  32'(rsp_valid), 32'd1);
            chk({tag, " bp_data"}, 32'(rsp_rdata), 32'(exp));
            chk({tag, " bp_busy"}, 32'(req_ready), 32'd0);
            if (i == hold - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, " rsp_clr"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle_rdy"}, 32'(req_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " rdy"},   32'(req_ready), 32'd0);
        chk({tag, " vld"},   32'(rsp_valid), 32'd0);
        chk({tag, " rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, " addr"},  32'(mem_addr), 32'd0);
        chk({tag, " ctl"},   ctl(), 32'b000);
        chk({tag, " err"},   32'(wr_err), 32'd0);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or required read data
        string         name;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vecs.push_back('{1'b1, 14'h0005, 16'hBEEF, "wr_beef"});
        vecs.push_back('{1'b0, 14'h0005, 16'hBEEF, "rd_beef"});
        vecs.push_back('{1'b1, 14'h0001, 16'h1111, "wr_b0"});
        vecs.push_back('{1'b1, 14'h1001, 16'h2222, "wr_b1"});
        vecs.push_back('{1'b1, 14'h2001, 16'h3333, "wr_b2"});
        vecs.push_back('{1'b1, 14'h3001, 16'h4444, "wr_b3"});
        vecs.push_back('{1'b0, 14'h0001, 16'h1111, "rd_b0"});
        vecs.push_back('{1'b0, 14'h1001, 16'h2222, "rd_b1"});
        vecs.push_back('{1'b0, 14'h2001, 16'h3333, "rd_b2"});
        vecs.push_back('{1'b0, 14'h3001, 16'h4444, "rd_b3"});

        // power-on reset
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        #1;
        chk("por_release_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);

        // directed table
        foreach (vecs[i]) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data, vecs[i].name);
            else            do_read(vecs[i].addr, 0, vecs[i].data, vecs[i].name);
        end

        // response backpressure
        do_read(14'h0005, 5, 16'hBEEF, "bp5");

        // async reset mid-cycle in the middle of WRITE: the write must not land
        do_write(14'h0010, 16'h5555, "pre_wr");
        wait_ready("rst_wr");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0010; req_wdata = 16'hAAAA;
        @(posedge clk);
        #2;
        chk("rst_wr_in_write", ctl(), 32'b110);
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check_reset_vals("rst_wr_async");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_release_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        do_read(14'h0010, 0, 16'h5555, "rd_after_abort");

        // async reset while a response is pending: response discarded
        wait_ready("rst_rsp");
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0005;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_pending", 32'(rsp_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_rsp_async");
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_rsp_idle", 32'(req_ready), 32'd1);

`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
        // read-back mismatch sets a sticky error cleared only by reset
        corrupt = 1'b1;
        do_write(14'h0020, 16'h1234, "vf_bad");
        corrupt = 1'b0;
        chk("vf_err_set", 32'(wr_err), 32'd1);
        do_write(14'h0021, 16'h0F0F, "vf_good");
        chk("vf_err_sticky", 32'(wr_err), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("vf_err_clr", 32'(wr_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`else
        corrupt = 1'b1;
        do_write(14'h0020, 16'h1234, "nvf_wr");
        corrupt = 1'b0;
        chk("nvf_err_zero", 32'(wr_err), 32'd0);
`endif

        // random traffic against the reference memory
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 7)) | (AW'($urandom_range(0, 3)) << 12);
            if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom), "rnd_wr");
            else do_read(a, int'($urandom_range(0, 2)), ref_rd(a), "rnd_rd");
        end
        chk("final_err", 32'(wr_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
